// File: rtl/regfile_pkg.sv
// Shared constants and types for the datapath register file.
// Default geometry is 16 entries of 16 bits each.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-entry busy bits.
// A lock sets an entry's bit and a writeback clears it. When both hit the same entry, the lock wins.
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              lock_en,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              clear_en,
  input  logic [ADDR_W-1:0] clear_addr,
  input  logic [ADDR_W-1:0] read_addr_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [DEPTH-1:0] busy;

  // Entry 0 is never marked busy when it is hardwired to zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (lock_en && (lock_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0)))
          busy[i] <= 1'b1;
        else if (clear_en && (clear_addr == ADDR_W'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  assign busy_a = busy[read_addr_a];
  assign busy_b = busy[read_addr_b];

endmodule

// File: rtl/register_file.sv
// Register file with two combinational read ports, one synchronous write port and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
import regfile_pkg::*;

module register_file #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              LockEnable,
  input  logic [ADDR_W-1:0] LockAddr,
  input  logic [ADDR_W-1:0] ReadAddrA,
  input  logic [ADDR_W-1:0] ReadAddrB,
  output logic [WIDTH-1:0]  ReadDataA,
  output logic [WIDTH-1:0]  ReadDataB,
  output logic              BusyA,
  output logic              BusyB
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             zero_a, zero_b;
  logic             hit_a, hit_b;
  logic             sb_busy_a, sb_busy_b;

  assign wr_ok  = WriteEnable && !((ZERO_REG != 0) && (WriteAddr == '0));
  assign zero_a = (ZERO_REG != 0) && (ReadAddrA == '0);
  assign zero_b = (ZERO_REG != 0) && (ReadAddrB == '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[WriteAddr] <= WriteData;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .Clock       (Clock),
    .Reset       (Reset),
    .lock_en     (LockEnable),
    .lock_addr   (LockAddr),
    .clear_en    (wr_ok),
    .clear_addr  (WriteAddr),
    .read_addr_a (ReadAddrA),
    .read_addr_b (ReadAddrB),
    .busy_a      (sb_busy_a),
    .busy_b      (sb_busy_b)
  );

`ifdef REGFILE_BYPASS_EN
  // A write hit forwards its data and hides the busy bit that the write is about to clear.
  assign hit_a = wr_ok && (ReadAddrA == WriteAddr);
  assign hit_b = wr_ok && (ReadAddrB == WriteAddr);
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  assign ReadDataA = zero_a ? '0 : (hit_a ? WriteData : mem[ReadAddrA]);
  assign ReadDataB = zero_b ? '0 : (hit_b ? WriteData : mem[ReadAddrB]);
  assign BusyA     = !zero_a && sb_busy_a && !hit_a;
  assign BusyB     = !zero_b && sb_busy_b && !hit_b;

endmodule
